// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stall, flush, bubble and forwarding selects.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_id_inst,
  input  logic        i_id_vld,
  input  logic        i_ex_taken,
  input  logic        i_dmem_ready,
  output logic        o_stall_if,
  output logic        o_stall_id,
  output logic        o_flush_id,
  output logic        o_bubble_ex,
  output logic        o_freeze,
  output logic [1:0]  o_fwd_a_sel,
  output logic [1:0]  o_fwd_b_sel,
  output logic [1:0]  o_state
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] o_stall_cnt
  , output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_LDUSE = 2'b01,
    ST_MWAIT = 2'b10
  } state_e;

  // Unused source operands and x0 destinations are stored as index 0 so no compare can hit them.
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              is_load;
    logic              is_store;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } shadow_t;

  state_e  state_q, state_d;
  shadow_t ex_q, mem_q, wb_q;
  shadow_t id_ent, ex_d;

  logic [6:0]        opc;
  logic [REG_AW-1:0] f_rd, f_rs1, f_rs2;
  logic              uses_rs1, uses_rs2, writes_rd, is_load, is_store;
  logic              ldu_hit, ev_mwait, ev_taken, ev_lduse;

  assign opc   = i_id_inst[6:0];
  assign f_rd  = i_id_inst[7 +: REG_AW];
  assign f_rs1 = i_id_inst[15 +: REG_AW];
  assign f_rs2 = i_id_inst[20 +: REG_AW];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    case (opc)
      OP_R:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      OP_IMM:    begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_LOAD:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
      OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_store = 1'b1; end
      OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_JAL:    writes_rd = 1'b1;
      OP_JALR:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_LUI:    writes_rd = 1'b1;
      OP_AUIPC:  writes_rd = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    id_ent          = '0;
    id_ent.vld      = 1'b1;
    id_ent.wr       = writes_rd && (f_rd != '0);
    id_ent.rd       = id_ent.wr ? f_rd : '0;
    id_ent.is_load  = is_load;
    id_ent.is_store = is_store;
    id_ent.rs1      = uses_rs1 ? f_rs1 : '0;
    id_ent.rs2      = uses_rs2 ? f_rs2 : '0;
  end

  // i_id_vld qualifies i_id_inst; i_dmem_ready is a level: a load/store in MEM completes only in a cycle where it is high.
  assign ldu_hit  = i_id_vld && ex_q.vld && ex_q.is_load && (ex_q.rd != '0) &&
                    ((id_ent.rs1 == ex_q.rd) || (id_ent.rs2 == ex_q.rd));
  assign ev_mwait = mem_q.vld && (mem_q.is_load || mem_q.is_store) && !i_dmem_ready;
  assign ev_taken = !i_reset && !ev_mwait && i_ex_taken;
  assign ev_lduse = !ev_mwait && !i_ex_taken && ldu_hit;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   state_d = ev_mwait ? ST_MWAIT : (ev_lduse ? ST_LDUSE : ST_RUN);
      ST_LDUSE: state_d = ev_mwait ? ST_MWAIT : ST_RUN;
      ST_MWAIT: state_d = ev_mwait ? ST_MWAIT : (ev_lduse ? ST_LDUSE : ST_RUN);
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    o_state     = state_d;
    o_freeze    = (state_d == ST_MWAIT);
    o_stall_if  = (state_d == ST_MWAIT) || (state_d == ST_LDUSE);
    o_stall_id  = (state_d == ST_MWAIT) || (state_d == ST_LDUSE);
    o_flush_id  = ev_taken;
    o_bubble_ex = ev_taken || (state_d == ST_LDUSE);
  end

  always_comb begin
    ex_d = id_ent;
    if (o_bubble_ex || o_flush_id || !i_id_vld) ex_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!o_freeze) begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Loads in MEM have no data yet, so only WB may forward a load result.
  always_comb begin
    o_fwd_a_sel = 2'b00;
    o_fwd_b_sel = 2'b00;
    if (ex_q.rs1 != '0) begin
      if (mem_q.vld && mem_q.wr && !mem_q.is_load && (mem_q.rd == ex_q.rs1)) o_fwd_a_sel = 2'b01;
      else if (wb_q.vld && wb_q.wr && (wb_q.rd == ex_q.rs1))                 o_fwd_a_sel = 2'b10;
    end
    if (ex_q.rs2 != '0) begin
      if (mem_q.vld && mem_q.wr && !mem_q.is_load && (mem_q.rd == ex_q.rs2)) o_fwd_b_sel = 2'b01;
      else if (wb_q.vld && wb_q.wr && (wb_q.rd == ex_q.rs2))                 o_fwd_b_sel = 2'b10;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{i_id_inst[31:25], i_id_inst[14:12], wb_q.is_load, wb_q.is_store,
                         wb_q.rs1, wb_q.rs2};

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (o_stall_if) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ev_taken)   flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: one expected control vector per driven ID cycle.
module tb_hazard_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_id_inst;
  logic        i_id_vld;
  logic        i_ex_taken;
  logic        i_dmem_ready;
  logic        o_stall_if, o_stall_id, o_flush_id, o_bubble_ex, o_freeze;
  logic [1:0]  o_fwd_a_sel, o_fwd_b_sel, o_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

  hazard_ctrl dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_id_inst    (i_id_inst),
    .i_id_vld     (i_id_vld),
    .i_ex_taken   (i_ex_taken),
    .i_dmem_ready (i_dmem_ready),
    .o_stall_if   (o_stall_if),
    .o_stall_id   (o_stall_id),
    .o_flush_id   (o_flush_id),
    .o_bubble_ex  (o_bubble_ex),
    .o_freeze     (o_freeze),
    .o_fwd_a_sel  (o_fwd_a_sel),
    .o_fwd_b_sel  (o_fwd_b_sel),
    .o_state      (o_state)
`ifdef HAZARD_PERF_EN
    , .o_stall_cnt (o_stall_cnt)
    , .o_flush_cnt (o_flush_cnt)
`endif
  );

  // clock / reset block
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int scn_cnt  = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [10:0] exp_q[$];
  logic [10:0] e_idle, e_lduse, e_taken, e_mwait;

  function automatic logic [10:0] ev(input logic sif, input logic sid, input logic fl,
                                     input logic bub, input logic frz, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic [1:0] st);
    return {sif, sid, fl, bub, frz, fa, fb, st};
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {o_stall_if, o_stall_id, o_flush_id, o_bubble_ex, o_freeze,
            o_fwd_a_sel, o_fwd_b_sel, o_state};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver: present one ID cycle, push its expectation, compare at the negedge
  task automatic step(input string tag, input logic [31:0] inst, input logic vld,
                      input logic taken, input logic rdy, input logic [10:0] exp);
    logic [10:0] want;
    i_id_inst    = inst;
    i_id_vld     = vld;
    i_ex_taken   = taken;
    i_dmem_ready = rdy;
    exp_q.push_back(exp);
    if (exp[1:0] != 2'b00) exp_stall++;
    if (exp[8]) exp_flush++;
    @(negedge i_clk);
    want = exp_q.pop_front();
    check(tag, {21'b0, obs_vec()}, {21'b0, want});
    @(posedge i_clk);
    #1;
  endtask

  task automatic nop(input string tag, input logic rdy, input logic taken, input logic [10:0] exp);
    step(tag, 32'h0, 1'b0, taken, rdy, exp);
  endtask

  task automatic do_reset();
`ifdef HAZARD_PERF_EN
    if (scn_cnt != 0) begin
      check("stall_cnt", o_stall_cnt, exp_stall);
      check("flush_cnt", o_flush_cnt, exp_flush);
    end
`endif
    scn_cnt++;
    i_id_inst    = 32'h0;
    i_id_vld     = 1'b0;
    i_ex_taken   = 1'b0;
    i_dmem_ready = 1'b1;
    i_reset      = 1'b1;
    #1;
    check("reset_out", {21'b0, obs_vec()}, 32'h0);
`ifdef HAZARD_PERF_EN
    check("reset_stall_cnt", o_stall_cnt, 32'h0);
    check("reset_flush_cnt", o_flush_cnt, 32'h0);
`endif
    exp_stall = 0;
    exp_flush = 0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    e_idle  = '0;
    e_lduse = ev(1, 1, 0, 1, 0, 2'b00, 2'b00, 2'b01);
    e_taken = ev(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
    e_mwait = ev(1, 1, 0, 0, 1, 2'b00, 2'b00, 2'b10);

    // MEM and WB forwarding
    do_reset();
    step("fwd_add", enc(OP_R, 5, 1, 2), 1, 0, 1, e_idle);
    step("fwd_sub", enc(OP_R, 6, 5, 3), 1, 0, 1, e_idle);
    step("fwd_mem", enc(OP_R, 11, 5, 6), 1, 0, 1, ev(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
    nop("fwd_mem_wb", 1, 0, ev(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00));
    nop("fwd_drain", 1, 0, e_idle);

    // MEM has priority over WB for the same register
    do_reset();
    step("pri_add", enc(OP_R, 5, 1, 2), 1, 0, 1, e_idle);
    step("pri_addi", enc(OP_IMM, 5, 1, 0), 1, 0, 1, e_idle);
    step("pri_use", enc(OP_R, 13, 5, 5), 1, 0, 1, e_idle);
    nop("pri_mem", 1, 0, ev(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00));

    // x0 never forwards; stores do not write; JAL/LUI write
    do_reset();
    step("x0_addi", enc(OP_IMM, 0, 0, 1), 1, 0, 1, e_idle);
    step("x0_add", enc(OP_R, 9, 0, 0), 1, 0, 1, e_idle);
    nop("x0_fwd", 1, 0, e_idle);
    step("sw_rdfield", enc(OP_STORE, 5, 1, 2), 1, 0, 1, e_idle);
    step("jal_x6", enc(OP_JAL, 6, 0, 0), 1, 0, 1, e_idle);
    step("use_5_6", enc(OP_R, 15, 5, 6), 1, 0, 1, e_idle);
    nop("sw_jal_fwd", 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    step("lui_x5", enc(OP_LUI, 5, 0, 0), 1, 0, 1, e_idle);
    step("beq_5_5", enc(OP_BRANCH, 0, 5, 5), 1, 0, 1, e_idle);
    nop("beq_fwd", 1, 0, ev(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00));

    // load-use: one bubble, then WB forwarding
    do_reset();
    step("ldu_lw", enc(OP_LOAD, 7, 1, 0), 1, 0, 1, e_idle);
    step("ldu_stall", enc(OP_R, 8, 7, 7), 1, 0, 1, e_lduse);
    step("ldu_retry", enc(OP_R, 8, 7, 7), 1, 0, 1, e_idle);
    nop("ldu_fwd_wb", 1, 0, ev(0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00));

    // no load-use: independent, rd==x0, invalid ID; store data dependency does stall
    do_reset();
    step("nl_lw", enc(OP_LOAD, 7, 1, 0), 1, 0, 1, e_idle);
    step("nl_indep", enc(OP_R, 8, 1, 2), 1, 0, 1, e_idle);
    step("nl_lw_x0", enc(OP_LOAD, 0, 1, 0), 1, 0, 1, e_idle);
    step("nl_use_x0", enc(OP_R, 9, 0, 0), 1, 0, 1, e_idle);
    step("nl_lw7", enc(OP_LOAD, 7, 1, 0), 1, 0, 1, e_idle);
    step("nl_novld", enc(OP_R, 8, 7, 7), 0, 0, 1, e_idle);
    step("sd_lw", enc(OP_LOAD, 7, 1, 0), 1, 0, 1, e_idle);
    step("sd_stall", enc(OP_STORE, 0, 1, 7), 1, 0, 1, e_lduse);
    step("sd_retry", enc(OP_STORE, 0, 1, 7), 1, 0, 1, e_idle);
    nop("sd_fwd", 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00));

    // load, load, use: one bubble per dependency
    do_reset();
    step("ll_lw1", enc(OP_LOAD, 1, 2, 0), 1, 0, 1, e_idle);
    step("ll_stall1", enc(OP_LOAD, 3, 1, 0), 1, 0, 1, e_lduse);
    step("ll_retry1", enc(OP_LOAD, 3, 1, 0), 1, 0, 1, e_idle);
    step("ll_stall2", enc(OP_R, 4, 3, 0), 1, 0, 1, ev(1, 1, 0, 1, 0, 2'b10, 2'b00, 2'b01));
    step("ll_retry2", enc(OP_R, 4, 3, 0), 1, 0, 1, e_idle);
    nop("ll_fwd", 1, 0, ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00));

    // taken branch cancels pending load-use; flushed ID never reaches EX
    do_reset();
    step("tk_lw", enc(OP_LOAD, 7, 1, 0), 1, 0, 1, e_idle);
    step("tk_cancel", enc(OP_R, 8, 7, 7), 1, 1, 1, e_taken);
    nop("tk_after", 1, 0, e_idle);
    step("tk_flush", enc(OP_R, 5, 1, 2), 1, 1, 1, e_taken);
    step("tk_sub", enc(OP_R, 6, 5, 3), 1, 0, 1, e_idle);
    nop("tk_nofwd", 1, 0, e_idle);

    // DMEM wait: freeze exactly while not ready, taken ignored then sampled at exit
    do_reset();
    step("mw_add", enc(OP_R, 5, 1, 2), 1, 0, 1, e_idle);
    step("mw_sw", enc(OP_STORE, 0, 1, 5), 1, 0, 1, e_idle);
    step("mw_or", enc(OP_R, 6, 5, 5), 1, 0, 1, ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    nop("mw_wait1", 0, 0, ev(1, 1, 0, 0, 1, 2'b10, 2'b10, 2'b10));
    nop("mw_wait2", 0, 1, ev(1, 1, 0, 0, 1, 2'b10, 2'b10, 2'b10));
    nop("mw_wait3", 0, 0, ev(1, 1, 0, 0, 1, 2'b10, 2'b10, 2'b10));
    nop("mw_exit_tk", 1, 1, ev(0, 0, 1, 1, 0, 2'b10, 2'b10, 2'b00));
    nop("mw_alu_mem", 0, 0, e_idle);
    step("mw_lw", enc(OP_LOAD, 7, 1, 0), 1, 0, 1, e_idle);
    nop("mw_lw_ex", 1, 0, e_idle);
    nop("mw_lw_wait", 0, 0, e_mwait);
    nop("mw_lw_done", 1, 0, e_idle);

    // asynchronous reset in the middle of a DMEM wait
    do_reset();
    step("ar_sw", enc(OP_STORE, 0, 1, 7), 1, 0, 1, e_idle);
    nop("ar_ex", 1, 0, e_idle);
    nop("ar_wait", 0, 0, e_mwait);
    check("ar_pre", {21'b0, obs_vec()}, {21'b0, e_mwait});
    i_reset = 1'b1;
    #1;
    check("ar_async", {21'b0, obs_vec()}, 32'h0);
`ifdef HAZARD_PERF_EN
    check("ar_stall_cnt", o_stall_cnt, 32'h0);
    check("ar_flush_cnt", o_flush_cnt, 32'h0);
`endif
    #1;
    i_reset   = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    @(posedge i_clk);
    #1;
    nop("ar_after", 0, 0, e_idle);

    do_reset();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
